// File: rtl/prach_pkg.sv
// prach_pkg: shared constants, sideband type and saturation helper for the PRACH half-band filters
package prach_pkg;

    localparam int HB5_NUM_CHN_USED = 48;
    localparam int HB5_UP_LATENCY   = 5;

    localparam logic signed [17:0] HB5_COE [4] = '{-18'sd616, 18'sd2989, -18'sd9818, 18'sd40178};

    typedef struct packed {
        logic       sync;
        logic       dv;
        logic [7:0] chn;
    } hb5_side_t;

    function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
        return (v[20:15] == {6{v[15]}}) ? v[15:0] : (v[20] ? 16'sh8000 : 16'sh7fff);
    endfunction

endpackage

// File: rtl/delay.sv
// delay: fixed-length register pipeline with synchronous clear
module delay #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DELAY];

    // shift din through DELAY registers, all cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DELAY-1];

endmodule

// File: rtl/prach_hb5_up.sv
// prach_hb5_up: half-band x2 interpolator for TDM PRACH streams producing dp1/dp2 polyphase branches
module prach_hb5_up
    import prach_pkg::*;
#(
    parameter int NUM_CHN_USED = HB5_NUM_CHN_USED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din_dq,
    input  logic               din_dv,
    input  logic [7:0]         din_chn,
    input  logic               sync_in,
    output logic signed [15:0] dout_dp1,
    output logic signed [15:0] dout_dp2,
    output logic               dout_dv,
    output logic [7:0]         dout_chn,
    output logic               sync_out
);

    localparam int C  = NUM_CHN_USED;
    localparam int N  = 7 * C;
    localparam int CW = $clog2(N + 1);

    logic signed [15:0] x [0:N];
    logic [CW-1:0]      cnt;
    logic [3:0]         ok;
    logic signed [15:0] d1 [3];
    logic signed [35:0] pair [2];
    logic signed [20:0] acc_hi;
    hb5_side_t          side_in;
    hb5_side_t          side_out;

    // tap delay line, advances only on accepted samples and is never cleared
    always_ff @(posedge clk) begin
        if (din_dv) begin
            x[0] <= din_dq;
            for (int i = 1; i <= N; i++) x[i] <= x[i-1];
        end
    end

    // priming counter of accepted samples, saturating once the line is full
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (din_dv && cnt != CW'(N)) cnt <= cnt + CW'(1);
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic signed [16:0] pre;
        logic signed [34:0] prod;
        // symmetric tap pre-add followed by the coefficient multiply
        always_ff @(posedge clk) begin
            pre  <= 17'(x[k*C]) + 17'(x[(7-k)*C]);
            prod <= 35'(pre) * 35'(HB5_COE[k]);
        end
    end

    // pairwise lane sums, centre-tap retiming and prime-flag alignment
    always_ff @(posedge clk) begin
        pair[0] <= 36'(g_lane[0].prod) + 36'(g_lane[1].prod);
        pair[1] <= 36'(g_lane[2].prod) + 36'(g_lane[3].prod);
        d1[0]   <= x[4*C];
        d1[1]   <= d1[0];
        d1[2]   <= d1[1];
        ok      <= {ok[2:0], cnt == CW'(N)};
    end

    assign acc_hi = 21'((37'(pair[0]) + 37'(pair[1])) >>> 16);

    // output stage: floor shift, saturate, and zero samples accepted while priming
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_dp1 <= '0;
            dout_dp2 <= '0;
        end else begin
            dout_dp1 <= ok[3] ? d1[2] : '0;
            dout_dp2 <= ok[3] ? sat16(acc_hi) : '0;
        end
    end

    assign side_in = {sync_in, din_dv, din_chn};

    delay #(
        .WIDTH(10),
        .DELAY(HB5_UP_LATENCY)
    ) u_side (
        .clk (clk),
        .rst (rst),
        .din (side_in),
        .dout(side_out)
    );

    assign {sync_out, dout_dv, dout_chn} = side_out;

endmodule

// File: doc/prach_hb5_up.md
# prach_hb5_up

Half-band ×2 interpolator for channel-interleaved (TDM) PRACH sample streams. It takes one 16-bit sample per valid cycle, with channel tag and frame sync, and produces two polyphase output branches. `dout_dp1` is the even/centre-tap phase; `dout_dp2` is the odd/symmetric-FIR phase. It sits on the upsampling path opposite the half-band decimator and emits the same `dp1`/`dp2` pair format that the decimator consumes. Gain is 2 so that unity amplitude is preserved across interpolation.

## Interface
- `NUM_CHN_USED`, default 48: number of interleaved active channels; sets the per-channel tap stride.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din_dq`  in  16: signed input sample.
- `din_dv`  in  1: input sample valid; at most one sample per cycle, arbitrary gaps allowed.
- `din_chn`  in  8: channel tag of `din_dq`; passed through, not interpreted.
- `sync_in`  in  1: frame-start marker; passed through, not interpreted.
- `dout_dp1`  out  16: signed even-phase output.
- `dout_dp2`  out  16: signed odd-phase output.
- `dout_dv`  out  1: output valid.
- `dout_chn`  out  8: delayed `din_chn`.
- `sync_out`  out  1: delayed `sync_in`.

## Operation
- **Delay line**
  - Let `C = NUM_CHN_USED`; taps `x[0..7C]`.
  - The line shifts only when `din_dv=1`: `x[0] <= din_dq`, `x[i] <= x[i-1]`.
  - Contents are not reset.
- **Odd phase**
  - Symmetric pre-add, then 18-bit signed coefficient multiply, with coefficients `H = {-616, 2989, -9818, 40178}` in Q17.
  - `s = H0*(x[0]+x[7C]) + H1*(x[C]+x[6C]) + H2*(x[2C]+x[5C]) + H3*(x[3C]+x[4C])`.
  - Widths: pre-add 17 b, products 35 b, accumulator 37 b.
  - `dp2 = sat16(s >>> 16)`: arithmetic shift (floor, no rounding), then saturate to [-32768, 32767].
- **Even phase**: `dp1 = x[4C]`, passed unscaled. This is the half-band centre tap ×2 gain.
- **Priming**
  - A counter counts accepted `din_dv` after reset and saturates at `7C`.
  - While the count is below `7C` at the time a sample is accepted, that sample's `dp1` and `dp2` are forced to 0.
  - `dout_dv`, `dout_chn` and `sync_out` still propagate normally for primed-out samples.
  - `sync_in` does not affect priming.
- **Sideband**: `{sync_in, din_dv, din_chn}` is delayed by exactly the datapath latency, so `dout_*` stay aligned.
- **Invalid cycles**: when `din_dv=0`, the delay line and prime counter hold and no output is marked valid. The pipeline still advances; data outputs on `dout_dv=0` cycles are don't-care.
- **Reset mid-operation**
  - Sideband pipeline and data output registers clear.
  - Prime counter returns to 0, so the next `7C` samples are zeroed.
  - In-flight samples are discarded; no valid output appears for them.

## Timing
- Fixed latency `L = 5` cycles from `din_dv` sampled high to `dout_dv` high, with outputs registered.
  - Stage 1: tap capture.
  - Stage 2: pre-add.
  - Stage 3: multiply.
  - Stage 4: pairwise sum.
  - Stage 5: final sum, shift, saturate and prime mask.
- `dp1` is retimed through 5 matching registers.
- Throughput: one sample per cycle, sustained; no backpressure.
- Reset values: `dout_dp1=0`, `dout_dp2=0`, `dout_dv=0`, `dout_chn=0`, `sync_out=0`.
- The first valid output after reset appears at cycle `t0+5` for an input accepted at `t0`.

## Structure
- **Shared package `prach_pkg`**
  - Coefficient array `HB5_COE[4]` (`logic signed [17:0]`), shared with the decimator.
  - `HB5_NUM_CHN_USED = 48`.
  - `HB5_UP_LATENCY = 5`.
- **Sub-module**: the existing generic `delay` (`WIDTH = 10`, `DELAY = HB5_UP_LATENCY`) carries the sideband.
  - Its reset is driven from `rst`, so the sideband clears on reset.
- Datapath: four identical pre-add/multiply lanes.
- Delay line: inferred shift register (SRL-friendly, no reset).

## Test plan
- **Reset / priming**
  - Stimulus: assert `rst` 3 cycles, then feed `7C = 336` samples of value 1000 on continuous `din_dv`.
  - Required: `dout_dv` follows `din_dv` with 5-cycle lag; every corresponding `dp1`/`dp2` = 0; sample 337 onward is unmasked.
- **Impulse**
  - Stimulus: after priming with zeros, a single 16384 on channel 0; zeros elsewhere.
  - Required channel-0 `dp2` over the next 8 channel-0 outputs: -154, 747, -2455, 10044, 10044, -2455, 747, -154.
  - Required channel-0 `dp1`: 16384 at the 5th channel-0 output (tap `4C`), else 0.
  - Required: other channels all 0.
- **DC**
  - Stimulus: constant 32767 on all channels, beyond priming.
  - Required: `dp2` = 32732, `dp1` = 32767.
- **Saturation**
  - Stimulus: +32767 on taps at `0C`, `2C` offsets' mirror-negative pattern (x=-32768 where H<0, +32767 where H>0).
  - Required: `dp2` = 32767; the inverted pattern gives -32768.
- **Gapped valid / sideband**
  - Stimulus: random `din_dv` duty 30%, `din_chn` counting 0..47, `sync_in` on chn 0.
  - Required: outputs match a bit-exact reference model; `dout_chn` and `sync_out` are aligned to 5 cycles.
- **Reset mid-stream**
  - Stimulus: `rst` pulsed for 1 cycle during continuous traffic.
  - Required: no `dout_dv` for in-flight samples; the next 336 outputs are zeroed.
